mac_accum_stage: RTL
====================

// Module: mac_accum_stage
// PURPOSE
//   Sequential multiply-accumulate stage downstream of the 8x8 unsigned array_mul.
//   Accepts a burst of LEN operand pairs (valid/ready) and feeds each pair to array_mul.
//   Registers the 16-bit product and sums it into a wide accumulator.
//   Emits one result per burst on a valid/ready output port.
// PARAMETERS
//   ACC_W  24  accumulator/result width; must be >= 16 (PROD_W)
//   CNT_W   8  width of burst length; max burst = 2**CNT_W-1 pairs
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      reset, synchronous, active-high
//   start      in   1      begin new burst; sampled only in IDLE
//   len        in   CNT_W  number of pairs in burst; sampled with start
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      stage can take a pair this cycle
//   a, b       in   8      unsigned operands
//   out_valid  out  1      acc_out holds the final burst sum
//   out_ready  in   1      consumer takes the result
//   acc_out    out  ACC_W  accumulated sum
//   busy       out  1      high in any state except IDLE
//   overflow   out  1      accumulator exceeded 2**ACC_W-1 during the burst (sticky per burst)
// BEHAVIOUR
//   Reset: state=IDLE; accumulator, counters, pipeline valids=0; in_ready=0, out_valid=0, busy=0, overflow=0, acc_out=0.
//   Reset mid-burst discards everything; no result is emitted.
//   FSM states: IDLE, RUN, DRAIN, DONE.
//   - IDLE: start=1 and len>0 -> RUN; remaining<=len; acc<=0; overflow<=0.
//     start=1 and len==0 -> DONE directly with acc=0. start outside IDLE is ignored.
//   - RUN: in_ready = (remaining != 0). Handshake = in_valid & in_ready.
//     On handshake: pair goes into the operand register (s1_valid=1); remaining decrements.
//     When the last pair is accepted -> DRAIN.
//   - DRAIN: in_ready=0; wait until both pipeline valids are 0 -> DONE.
//   - DONE: out_valid=1 and acc_out stable until out_ready=1; then -> IDLE.
//     The start input is not observed on the DONE->IDLE cycle.
//   Pipeline (one pair/cycle max, no stall inside):
//     c0 accept -> c1 operand reg drives array_mul, product registered -> c2 acc += product.
//     out_valid asserts on cycle c3 after the last accept. Example: last accept at c0 -> out_valid at c3.
//   Arithmetic: product zero-extended to ACC_W; the add uses ACC_W+1 bits; carry-out sets overflow.
//   Bubbles (in_valid=0) in RUN stall only acceptance; in-flight pairs still complete.
// CONFIGURATION
//   SATURATE_EN defined: on carry-out, acc clamps to 2**ACC_W-1 and stays there for the rest of the burst; overflow=1.
//   SATURATE_EN undefined: acc wraps modulo 2**ACC_W; overflow=1 (sticky until next start).
// STRUCTURE
//   Package mac_pkg holds:
//     - state enum {IDLE, RUN, DRAIN, DONE}
//     - localparam PROD_W=16, OP_W=8
//     - function sat_add(acc, prod), used by both configurations
//   Sub-module mul_pipe_reg: operand register + array_mul instance + product register, each with its valid bit.
//   The top holds the FSM, burst counter, accumulator and output handshake.
// TESTING
//   1 len=3, pairs (2,3),(4,5),(255,255), in_valid=1 continuous -> acc_out=65051, out_valid 3 cycles after 3rd accept, overflow=0.
//   2 start with len=0 -> next cycle DONE, out_valid=1, acc_out=0; hold out_ready=0 for 5 cycles -> output stable.
//   3 ACC_W=16, len=2, (255,255)x2 -> overflow=1.
//     Without SATURATE_EN: acc_out=0xFC02. With SATURATE_EN: acc_out=0xFFFF.
//   4 len=4 with in_valid toggling 1/0 -> exactly 4 handshakes; in_ready=0 after the 4th; sum correct.
//   5 Assert rst during RUN after 2 accepts -> next cycle IDLE, busy=0, out_valid=0; a new burst len=1 (7,9) -> acc_out=63.
//   6 start pulsed in RUN/DONE -> ignored. len/result of the current burst unchanged.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types, widths and the accumulate helper for the MAC stage.
// Optional feature macro: SATURATE_EN (selects clamp-on-carry accumulation).
package mac_pkg;

    localparam int PROD_W    = 16;
    localparam int OP_W      = 8;
    localparam int ACC_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef logic [ACC_MAX_W-1:0] wide_t;

    // Adds in w+1 bits; returns {carry, sum}. With sat set, a carry clamps
    // the sum to all-ones of width w, otherwise the sum wraps modulo 2**w.
    function automatic logic [ACC_MAX_W:0] sat_add(
        input wide_t       acc,
        input wide_t       prod,
        input int unsigned w,
        input logic        sat
    );
        logic [ACC_MAX_W:0] s;
        wide_t              mask;
        logic               c;
        mask = '1;
        if (w < ACC_MAX_W)
            mask = (wide_t'(1) << w) - wide_t'(1);
        s = {1'b0, acc} + {1'b0, prod};
        c = s[w[6:0]];
        if (c && sat)
            s[ACC_MAX_W-1:0] = mask;
        else
            s[ACC_MAX_W-1:0] = s[ACC_MAX_W-1:0] & mask;
        return {c, s[ACC_MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/array_mul.sv
// 8x8 unsigned array multiplier built from shifted partial products.
// Ports: a, b operands in; p 16-bit product out (purely combinational).
module array_mul
    import mac_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);

    always_comb begin
        p = '0;
        for (int i = 0; i < OP_W; i++) begin
            if (b[i])
                p = p + (PROD_W'(a) << i);
        end
    end

endmodule

// File: rtl/mul_pipe_reg.sv
// Operand register -> array_mul -> product register, each with a valid bit.
// Ports: clk, rst, load/a/b in; s1_valid, p_valid, prod out.
module mul_pipe_reg
    import mac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              s1_valid,
    output logic              p_valid,
    output logic [PROD_W-1:0] prod
);

    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [PROD_W-1:0] mul_p;

    array_mul u_mul (
        .a (op_a),
        .b (op_b),
        .p (mul_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            p_valid  <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            prod     <= '0;
        end else begin
            s1_valid <= load;
            p_valid  <= s1_valid;
            if (load) begin
                op_a <= a;
                op_b <= b;
            end
            if (s1_valid)
                prod <= mul_p;
        end
    end

endmodule

// File: rtl/mac_accum_stage.sv
// Burst multiply-accumulate: LEN operand pairs in, one summed result out.
// Ports: clk, rst, start, len, in_valid/in_ready, a, b, out_valid/out_ready,
// acc_out, busy, overflow. Macro SATURATE_EN clamps the sum on carry-out.
module mac_accum_stage
    import mac_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             busy,
    output logic             overflow
);

`ifdef SATURATE_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   remaining;
    logic [ACC_W-1:0]   acc;
    logic               ovf;
    logic               hs;
    logic               s1_valid;
    logic               p_valid;
    logic [PROD_W-1:0]  prod;
    logic [ACC_MAX_W:0] add_r;
    logic               unused_hi;

    assign hs = in_valid & in_ready;

    mul_pipe_reg u_pipe (
        .clk      (clk),
        .rst      (rst),
        .load     (hs),
        .a        (a),
        .b        (b),
        .s1_valid (s1_valid),
        .p_valid  (p_valid),
        .prod     (prod)
    );

    assign add_r = sat_add(wide_t'(acc), wide_t'(prod), unsigned'(ACC_W), SAT);
    assign unused_hi = ^add_r[ACC_MAX_W-1:ACC_W];

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // DRAIN leaves once the operand stage is empty: a product still in the
    // product register retires into acc on that same edge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = (len == '0) ? DONE : RUN;
            end
            RUN: begin
                if (hs && remaining == CNT_W'(1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!s1_valid)
                    state_nxt = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == RUN) && (remaining != '0);
        busy      = (state != IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (state == IDLE && start) begin
            remaining <= len;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            if (hs)
                remaining <= remaining - CNT_W'(1);
            if (p_valid) begin
                acc <= add_r[ACC_W-1:0];
                if (add_r[ACC_MAX_W])
                    ovf <= 1'b1;
            end
        end
    end

    assign acc_out  = acc;
    assign overflow = ovf;

endmodule
